// File: rtl/apb_sram_param.sv
// apb_sram_param: parametrised APB slave fronting a word-organised SRAM array.
// Optional feature macro: APB_SRAM_STRB_EN (byte-lane writes driven by pstrb).
// The default build ignores pstrb, and every write updates the full word.
// Out-of-range word indices complete with pslverr and never touch the array.
module apb_sram_param #(
  parameter int DW       = 32,
  parameter int AW       = 10,
  parameter int DEPTH    = 256,
  parameter int WAIT_CYC = 0
) (
  input  logic            clk,
  input  logic            rstn,
  input  logic            psel,
  input  logic            penable,
  input  logic [AW-1:0]   paddr,
  input  logic            pwrite,
  input  logic [DW-1:0]   pwdata,
  input  logic [DW/8-1:0] pstrb,
  output logic            pready,
  output logic [DW-1:0]   prdata,
  output logic            pslverr
);

  localparam int NB  = DW / 8;
  localparam int OFF = $clog2(NB);
  localparam int IW  = AW - OFF;
  localparam int XW  = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [IW:0] DEPTH_W = (IW + 1)'(DEPTH);
  localparam logic [3:0]  WAIT_W  = 4'(WAIT_CYC);

  typedef enum logic [0:0] {
    ST_IDLE   = 1'b0,
    ST_ACCESS = 1'b1
  } state_e;

  state_e          state_q;
  logic [3:0]      cnt_q;
  logic [XW-1:0]   idx_q;
  logic            write_q;
  logic            oor_q;
  logic            pready_q;
  logic            pslverr_q;
  logic [DW-1:0]   prdata_q;

  logic [DW-1:0]   mem [0:DEPTH-1];

  logic [IW-1:0]   idx_s;
  logic            oor_s;
  logic            wr_en_s;
  logic [DW-1:0]   word_d;

  // Word index and range check are taken straight from the setup-phase address.
  assign idx_s   = paddr[AW-1:OFF];
  assign oor_s   = ({1'b0, idx_s} >= DEPTH_W);
  // The array is written only on the completion edge of an in-range write.
  assign wr_en_s = (state_q == ST_ACCESS) & psel & penable & pready_q & write_q & ~oor_q;

  // Sub-word address bits never select anything.
  generate
    if (OFF > 0) begin : g_lsb
      logic unused_lsb_s;
      assign unused_lsb_s = ^paddr[OFF-1:0];
    end
  endgenerate

`ifdef APB_SRAM_STRB_EN
  logic [DW-1:0] old_s;
  assign old_s = mem[idx_q];

  // Merge the enabled byte lanes of pwdata into the currently stored word.
  always_comb begin
    word_d = old_s;
    for (int i = 0; i < NB; i++) begin
      if (pstrb[i]) begin
        word_d[i*8 +: 8] = pwdata[i*8 +: 8];
      end else begin
        word_d[i*8 +: 8] = old_s[i*8 +: 8];
      end
    end
  end
`else
  logic unused_strb_s;
  assign unused_strb_s = ^pstrb;

  // Without byte strobes the whole word is replaced by pwdata.
  always_comb begin
    word_d = pwdata;
  end
`endif

  // SRAM array write port; the array deliberately has no reset.
  always_ff @(posedge clk) begin
    if (wr_en_s) begin
      mem[idx_q] <= word_d;
    end
  end

  // Transfer FSM: setup latches the request, access counts wait states and completes.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q   <= ST_IDLE;
      cnt_q     <= 4'd0;
      idx_q     <= '0;
      write_q   <= 1'b0;
      oor_q     <= 1'b0;
      pready_q  <= 1'b0;
      pslverr_q <= 1'b0;
      prdata_q  <= '0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (psel && !penable) begin
            state_q   <= ST_ACCESS;
            cnt_q     <= WAIT_W;
            idx_q     <= idx_s[XW-1:0];
            write_q   <= pwrite;
            oor_q     <= oor_s;
            pready_q  <= (WAIT_W == 4'd0);
            pslverr_q <= (WAIT_W == 4'd0) & oor_s;
            if (!pwrite) begin
              prdata_q <= oor_s ? '0 : mem[idx_s[XW-1:0]];
            end
          end else begin
            pready_q  <= 1'b0;
            pslverr_q <= 1'b0;
          end
        end
        ST_ACCESS: begin
          if (!psel) begin
            // Abandoned transfer: drop it without writing.
            state_q   <= ST_IDLE;
            cnt_q     <= 4'd0;
            pready_q  <= 1'b0;
            pslverr_q <= 1'b0;
          end else if (penable && pready_q) begin
            state_q   <= ST_IDLE;
            pready_q  <= 1'b0;
            pslverr_q <= 1'b0;
          end else if (penable && (cnt_q != 4'd0)) begin
            cnt_q <= cnt_q - 4'd1;
            if (cnt_q == 4'd1) begin
              pready_q  <= 1'b1;
              pslverr_q <= oor_q;
            end
          end
        end
        default: begin
          state_q   <= ST_IDLE;
          cnt_q     <= 4'd0;
          pready_q  <= 1'b0;
          pslverr_q <= 1'b0;
        end
      endcase
    end
  end

  assign pready  = pready_q;
  assign pslverr = pslverr_q;
  assign prdata  = prdata_q;

endmodule

// File: tb/tb_apb_sram_param.sv
// Bench for apb_sram_param: three instances (default, WAIT_CYC=3, DEPTH=128)
// share one APB bus, with a separate psel for each instance.
module tb_apb_sram_param;

`ifdef APB_SRAM_STRB_EN
  localparam bit STRB = 1'b1;
`else
  localparam bit STRB = 1'b0;
`endif

  logic        clk;
  logic        rstn;
  logic [2:0]  psel_v;
  logic        penable;
  logic        pwrite;
  logic [9:0]  paddr;
  logic [31:0] pwdata;
  logic [3:0]  pstrb;
  logic        pready_w [3];
  logic [31:0] prdata_w [3];
  logic        pslverr_w [3];

  int n_cmp;
  int n_fail;

  typedef struct {
    int          sel;
    logic        wr;
    logic [9:0]  addr;
    logic [31:0] wdata;
    logic [3:0]  strb;
    logic [31:0] exp_rd;
    logic        exp_err;
    int          exp_waits;
  } vec_t;

  vec_t vecs[$];

  apb_sram_param #(.DW(32), .AW(10), .DEPTH(256), .WAIT_CYC(0)) u_dut0 (
    .clk(clk), .rstn(rstn), .psel(psel_v[0]), .penable(penable), .paddr(paddr),
    .pwrite(pwrite), .pwdata(pwdata), .pstrb(pstrb),
    .pready(pready_w[0]), .prdata(prdata_w[0]), .pslverr(pslverr_w[0]));

  apb_sram_param #(.DW(32), .AW(10), .DEPTH(256), .WAIT_CYC(3)) u_dut1 (
    .clk(clk), .rstn(rstn), .psel(psel_v[1]), .penable(penable), .paddr(paddr),
    .pwrite(pwrite), .pwdata(pwdata), .pstrb(pstrb),
    .pready(pready_w[1]), .prdata(prdata_w[1]), .pslverr(pslverr_w[1]));

  apb_sram_param #(.DW(32), .AW(10), .DEPTH(128), .WAIT_CYC(0)) u_dut2 (
    .clk(clk), .rstn(rstn), .psel(psel_v[2]), .penable(penable), .paddr(paddr),
    .pwrite(pwrite), .pwdata(pwdata), .pstrb(pstrb),
    .pready(pready_w[2]), .prdata(prdata_w[2]), .pslverr(pslverr_w[2]));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic add(input int s, input logic wr, input logic [9:0] a, input logic [31:0] d,
                     input logic [3:0] st, input logic [31:0] e, input logic ee, input int w);
    vec_t v;
    v.sel = s; v.wr = wr; v.addr = a; v.wdata = d; v.strb = st;
    v.exp_rd = e; v.exp_err = ee; v.exp_waits = w;
    vecs.push_back(v);
  endtask

  // One full transfer; returns prdata from the first access cycle and at pready.
  task automatic apb_xfer(input int s, input logic wr, input logic [9:0] a, input logic [31:0] d,
                          input logic [3:0] st, output logic [31:0] rd_first,
                          output logic [31:0] rd, output logic err, output int waits);
    @(negedge clk);
    psel_v = 3'b000; psel_v[s] = 1'b1;
    penable = 1'b0; pwrite = wr; paddr = a; pwdata = d; pstrb = st;
    @(negedge clk);
    penable = 1'b1;
    rd_first = prdata_w[s];
    waits = 0;
    while (pready_w[s] !== 1'b1 && waits < 40) begin
      @(negedge clk);
      waits++;
    end
    rd = prdata_w[s];
    err = pslverr_w[s];
  endtask

  task automatic apb_idle();
    @(negedge clk);
    psel_v = 3'b000;
    penable = 1'b0;
  endtask

  initial begin
    logic [31:0] rf, rd;
    logic        er;
    int          w;
    n_cmp = 0; n_fail = 0;
    rstn = 1'b0; psel_v = 3'b000; penable = 1'b0; pwrite = 1'b0;
    paddr = 10'h000; pwdata = 32'h0; pstrb = 4'h0;

    // Vector table: sel, wr, addr, wdata, strb, exp_rd, exp_err, exp_waits
    add(0, 1'b1, 10'h3c4, 32'hffff_ff01, 4'hf, 32'h0, 1'b0, 0);
    add(0, 1'b0, 10'h3c4, 32'h0, 4'h0, 32'hffff_ff01, 1'b0, 0);
    add(0, 1'b1, 10'h000, 32'h1122_3344, 4'hf, 32'h0, 1'b0, 0);
    add(0, 1'b1, 10'h000, 32'haabb_ccdd, 4'b0101, 32'h0, 1'b0, 0);
    add(0, 1'b0, 10'h000, 32'h0, 4'h0, STRB ? 32'h11bb_33dd : 32'haabb_ccdd, 1'b0, 0);
    add(0, 1'b1, 10'h004, 32'h5566_7788, 4'hf, 32'h0, 1'b0, 0);
    add(0, 1'b1, 10'h004, 32'h9999_9999, 4'h0, 32'h0, 1'b0, 0);
    add(0, 1'b0, 10'h004, 32'h0, 4'h0, STRB ? 32'h5566_7788 : 32'h9999_9999, 1'b0, 0);
    add(0, 1'b1, 10'h3fc, 32'hcafe_f00d, 4'hf, 32'h0, 1'b0, 0);
    add(0, 1'b0, 10'h3fc, 32'h0, 4'h0, 32'hcafe_f00d, 1'b0, 0);
    add(0, 1'b0, 10'h3c7, 32'h0, 4'h0, 32'hffff_ff01, 1'b0, 0);
    add(1, 1'b1, 10'h010, 32'h0bad_f00d, 4'hf, 32'h0, 1'b0, 3);
    add(1, 1'b0, 10'h010, 32'h0, 4'h0, 32'h0bad_f00d, 1'b0, 3);
    add(2, 1'b1, 10'h000, 32'h1234_5678, 4'hf, 32'h0, 1'b0, 0);
    add(2, 1'b1, 10'h200, 32'hdead_beef, 4'hf, 32'h0, 1'b1, 0);
    add(2, 1'b0, 10'h200, 32'h0, 4'h0, 32'h0, 1'b1, 0);
    add(2, 1'b0, 10'h000, 32'h0, 4'h0, 32'h1234_5678, 1'b0, 0);
    add(2, 1'b1, 10'h1fc, 32'h0f0f_0f0f, 4'hf, 32'h0, 1'b0, 0);
    add(2, 1'b0, 10'h1fc, 32'h0, 4'h0, 32'h0f0f_0f0f, 1'b0, 0);
    add(2, 1'b0, 10'h3fc, 32'h0, 4'h0, 32'h0, 1'b1, 0);

    // Reset state
    repeat (3) @(negedge clk);
    rstn = 1'b1;
    @(negedge clk);
    for (int k = 0; k < 3; k++) begin
      chk($sformatf("rst_pready%0d", k), {31'b0, pready_w[k]}, 32'h0);
      chk($sformatf("rst_pslverr%0d", k), {31'b0, pslverr_w[k]}, 32'h0);
      chk($sformatf("rst_prdata%0d", k), prdata_w[k], 32'h0);
    end

    // Table-driven transfers
    for (int i = 0; i < vecs.size(); i++) begin
      apb_xfer(vecs[i].sel, vecs[i].wr, vecs[i].addr, vecs[i].wdata, vecs[i].strb, rf, rd, er, w);
      if (!vecs[i].wr) begin
        chk($sformatf("v%0d_rd", i), rd, vecs[i].exp_rd);
        chk($sformatf("v%0d_rd_first", i), rf, vecs[i].exp_rd);
      end
      chk($sformatf("v%0d_err", i), {31'b0, er}, {31'b0, vecs[i].exp_err});
      chk($sformatf("v%0d_waits", i), w, vecs[i].exp_waits);
      apb_idle();
    end
    @(negedge clk);
    chk("idle_pslverr", {31'b0, pslverr_w[2]}, 32'h0);
    chk("idle_pready", {31'b0, pready_w[2]}, 32'h0);

    // Back-to-back with psel held high
    apb_xfer(0, 1'b1, 10'h100, 32'ha5a5_0001, 4'hf, rf, rd, er, w);
    chk("b2b_w0_waits", w, 0);
    apb_xfer(0, 1'b1, 10'h104, 32'h5a5a_0002, 4'hf, rf, rd, er, w);
    chk("b2b_w1_waits", w, 0);
    apb_xfer(0, 1'b0, 10'h100, 32'h0, 4'h0, rf, rd, er, w);
    chk("b2b_rA", rd, 32'ha5a5_0001);
    chk("b2b_r0_waits", w, 0);
    apb_xfer(0, 1'b0, 10'h104, 32'h0, 4'h0, rf, rd, er, w);
    chk("b2b_rB", rd, 32'h5a5a_0002);
    apb_idle();

    // Write data sampled at completion; address changes during access ignored
    @(negedge clk);
    psel_v = 3'b010; penable = 1'b0; pwrite = 1'b1; paddr = 10'h040; pwdata = 32'h0000_0001; pstrb = 4'hf;
    @(negedge clk);
    penable = 1'b1; pwdata = 32'h7777_8888; paddr = 10'h044;
    w = 0;
    while (pready_w[1] !== 1'b1 && w < 40) begin
      @(negedge clk);
      w++;
    end
    chk("late_wdata_waits", w, 3);
    apb_idle();
    apb_xfer(1, 1'b0, 10'h040, 32'h0, 4'h0, rf, rd, er, w);
    chk("late_wdata_rd", rd, 32'h7777_8888);
    apb_idle();

    // psel dropped during access: no write, pready stays low
    apb_xfer(1, 1'b1, 10'h030, 32'h1357_2468, 4'hf, rf, rd, er, w);
    apb_idle();
    @(negedge clk);
    psel_v = 3'b010; penable = 1'b0; pwrite = 1'b1; paddr = 10'h030; pwdata = 32'hffff_ffff;
    @(negedge clk);
    penable = 1'b1;
    @(negedge clk);
    psel_v = 3'b000; penable = 1'b0;
    @(negedge clk);
    chk("drop_pready", {31'b0, pready_w[1]}, 32'h0);
    apb_xfer(1, 1'b0, 10'h030, 32'h0, 4'h0, rf, rd, er, w);
    chk("drop_rd", rd, 32'h1357_2468);
    chk("drop_rd_waits", w, 3);
    apb_idle();

    // Reset pulsed during a waited write
    apb_xfer(1, 1'b1, 10'h020, 32'h2468_1357, 4'hf, rf, rd, er, w);
    apb_idle();
    apb_xfer(1, 1'b0, 10'h020, 32'h0, 4'h0, rf, rd, er, w);
    chk("pre_rst_rd", rd, 32'h2468_1357);
    apb_idle();
    @(negedge clk);
    psel_v = 3'b010; penable = 1'b0; pwrite = 1'b1; paddr = 10'h020; pwdata = 32'h0f0f_0f0f;
    @(negedge clk);
    penable = 1'b1;
    @(negedge clk);
    rstn = 1'b0;
    #1;
    chk("midrst_pready", {31'b0, pready_w[1]}, 32'h0);
    chk("midrst_prdata", prdata_w[1], 32'h0);
    @(negedge clk);
    psel_v = 3'b000; penable = 1'b0;
    rstn = 1'b1;
    apb_xfer(1, 1'b0, 10'h020, 32'h0, 4'h0, rf, rd, er, w);
    chk("post_rst_rd", rd, 32'h2468_1357);
    chk("post_rst_err", {31'b0, er}, 32'h0);
    apb_idle();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
